// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// This module sequences stalls and flushes for the 5-stage pipeline. It drives
// the enable and clear of the four stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB)
// and the PC enable. It handles three hazards:
//   - data-memory wait states: the whole front end freezes and WB gets a bubble,
//   - taken-branch redirects: IF/ID and ID/EX are flushed, and IF/ID keeps being
//     cleared for REDIRECT_BUBBLES further cycles to cover the fetch latency,
//   - load-use hazards: the front end holds for one cycle and ID/EX gets a bubble.
// Per cycle, a memory wait takes priority over a redirect, a redirect over a
// load-use hazard, and a load-use hazard over normal advance. The pipeline
// outputs are combinational from the state and the inputs. Clear wins over
// enable at every latch.
//
// Parameters
//   REG_W             register index width
//   REDIRECT_BUBBLES  extra cycles IF/ID is cleared after a redirect (0..15)
//   MEM_TIMEOUT       wait cycles before err_timeout is raised; 0 = never
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   id_rs1/id_rs2         ID-stage source indices
//   id_use_rs1/id_use_rs2 ID instruction actually reads that source
//   ex_rd, ex_is_load,
//   ex_reg_write          EX-stage destination, load flag, write flag
//   ex_redirect           EX branch/jump taken
//   mem_req, mem_ready    MEM-stage data access handshake
//   pc_en, *_en, *_clr    PC and stage-latch controls
//   err_timeout           sticky memory-timeout flag
//
// Optional build macro PIPE_CTRL_PERF_EN adds perf_stall_cnt and
// perf_flush_cnt (32-bit wrapping event counters).
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_W            = 5,
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_reg_write,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_clr,
    output logic             id_ex_en,
    output logic             id_ex_clr,
    output logic             ex_mem_en,
    output logic             ex_mem_clr,
    output logic             mem_wb_en,
    output logic             mem_wb_clr,
    output logic             err_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0]  BUB_LOAD = 4'(REDIRECT_BUBBLES);
    localparam logic [15:0] TO_LIMIT = 16'(MEM_TIMEOUT);
    localparam logic        TO_EN    = (MEM_TIMEOUT != 0);

    state_t      state_q, state_d;
    // The state to resume after a memory wait (1 = REDIRECT, 0 = RUN).
    logic        ret_redir_q, ret_redir_d;
    logic [3:0]  bub_q, bub_d;
    logic [15:0] wait_q, wait_d;
    logic        err_q, err_d;

    logic mem_wait;
    logic in_redir;
    logic rs1_hit, rs2_hit;
    logic load_use;
    logic timeout_hit;
    logic stall_evt;
    logic flush_evt;

    assign mem_wait = mem_req & ~mem_ready;

    // A cycle that releases a wait behaves as a cycle in the saved state.
    // This lets a bubble sequence that a wait interrupted resume seamlessly.
    assign in_redir = (state_q == S_REDIRECT) |
                      ((state_q == S_MEM_WAIT) & ret_redir_q);

    assign rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use = ex_is_load & ex_reg_write & (ex_rd != '0) & (rs1_hit | rs2_hit);

    // The error is visible in the same cycle that the count reaches the limit.
    assign timeout_hit = TO_EN & mem_wait & (wait_q == TO_LIMIT);

    always_comb begin
        state_d     = state_q;
        ret_redir_d = ret_redir_q;
        bub_d       = bub_q;
        wait_d      = wait_q;
        err_d       = err_q | timeout_hit;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;

        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_clr   = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_clr   = 1'b0;
        ex_mem_en   = 1'b1;
        ex_mem_clr  = 1'b0;
        mem_wb_en   = 1'b1;
        mem_wb_clr  = 1'b0;

        if (mem_wait) begin
            // Freeze everything up to EX/MEM. The access in MEM is not done, so
            // WB receives a bubble rather than a second copy of the instruction.
            // A pending redirect stays frozen in EX until the release cycle.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_clr  = 1'b1;
            state_d     = S_MEM_WAIT;
            ret_redir_d = in_redir;
            wait_d      = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
            stall_evt   = 1'b1;
        end else begin
            wait_d = '0;
            if (ex_redirect) begin
                if_id_clr = 1'b1;
                id_ex_clr = 1'b1;
                flush_evt = 1'b1;
                if (BUB_LOAD != 4'd0) begin
                    bub_d   = BUB_LOAD;
                    state_d = S_REDIRECT;
                end else begin
                    bub_d   = 4'd0;
                    state_d = S_RUN;
                end
            end else if (in_redir) begin
                // ID holds a fetch bubble, so no load-use check is needed here.
                if_id_clr = 1'b1;
                bub_d     = (bub_q != 4'd0) ? bub_q - 4'd1 : 4'd0;
                state_d   = (bub_q <= 4'd1) ? S_RUN : S_REDIRECT;
            end else begin
                state_d = S_RUN;
                if (load_use) begin
                    // Hold PC and IF/ID and inject one bubble into EX. On the
                    // next cycle the load is in MEM and the hazard is gone.
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_clr = 1'b1;
                    stall_evt = 1'b1;
                end
            end
        end

        if (reset) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            if_id_clr  = 1'b1;
            id_ex_en   = 1'b0;
            id_ex_clr  = 1'b1;
            ex_mem_en  = 1'b0;
            ex_mem_clr = 1'b1;
            mem_wb_en  = 1'b0;
            mem_wb_clr = 1'b1;
        end
    end

    assign err_timeout = ~reset & (err_q | timeout_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_RUN;
            ret_redir_q <= 1'b0;
            bub_q       <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_redir_q <= ret_redir_d;
            bub_q       <= bub_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_evt) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_evt) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    // The event strobes have no consumer in this build.
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule
